ram_rw_ctrl: RTL

Write-then-verify controller that sits directly upstream of the single-port block RAM in the `ip_lport_ram` design. On a start pulse it fills the RAM with an address-derived pattern, reads every location back, and compares each read word against the expected value. It reports completion, a sticky error flag and a mismatch count. It is the traffic source and checker for the RAM IP on the board and in simulation.

---
 rtl/ram_rw_pkg.sv | 26 ++
 rtl/rd_chk_pipe.sv | 42 ++++
 rtl/ram_rw_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ram_rw_pkg.sv
// ============================================================================
//  Module   : ram_rw_pkg
//  Purpose  : Shared state encoding and default parameters for ram_rw_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ram_rw_pkg;

   localparam int DEF_ADDR_W = 5;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 32;
   localparam int DEF_RD_LAT = 1;
   localparam int DEF_SEED   = 0;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_READ  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

endpackage

`default_nettype wire

// File: rtl/rd_chk_pipe.sv
// ============================================================================
//  Module   : rd_chk_pipe
//  Purpose  : Delay line carrying {valid, expected} alongside RAM read latency.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rd_chk_pipe #(
   parameter int STAGES = 1,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_exp,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_exp
);

   logic [STAGES-1:0] r_valid;
   logic [DATA_W-1:0] r_exp [STAGES];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
         for (int i = 0; i < STAGES; i++) r_exp[i] <= '0;
      end else begin
         r_valid[0] <= i_valid;
         r_exp[0]   <= i_exp;
         for (int i = 1; i < STAGES; i++) begin
            r_valid[i] <= r_valid[i-1];
            r_exp[i]   <= r_exp[i-1];
         end
      end
   end

   assign o_valid = r_valid[STAGES-1];
   assign o_exp   = r_exp[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/ram_rw_ctrl.sv
// ============================================================================
//  Module   : ram_rw_ctrl
//  Purpose  : Fills a single-port RAM with an address pattern, reads it back
//             and counts mismatches.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_rw_ctrl
   import ram_rw_pkg::*;
#(
   parameter int          ADDR_W = DEF_ADDR_W,
   parameter int          DATA_W = DEF_DATA_W,
   parameter int          DEPTH  = DEF_DEPTH,
   parameter int          RD_LAT = DEF_RD_LAT,
   parameter int unsigned SEED   = DEF_SEED
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              start,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wr_data,
   input  logic [DATA_W-1:0] ram_rd_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   err_cnt
);

   localparam logic [ADDR_W-1:0] c_last_addr  = ADDR_W'(DEPTH - 1);
   localparam logic [DATA_W-1:0] c_seed       = DATA_W'(SEED);
   localparam logic [1:0]        c_drain_last = 2'(RD_LAT - 1);

   // Zero-extend or truncate the address to DATA_W before adding the seed.
   function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
      logic [ADDR_W+DATA_W-1:0] wide;
      wide = {{DATA_W{1'b0}}, a};
      return wide[DATA_W-1:0] + c_seed;
   endfunction

   state_t              r_state, w_state_nxt;
   logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
   logic [1:0]          r_drain, w_drain_nxt;
   logic                r_en, r_we, r_busy, r_done, r_err;
   logic [DATA_W-1:0]   r_wr_data;
   logic [ADDR_W:0]     r_err_cnt;
   logic                w_accept, w_chk_valid, w_mismatch;
   logic [DATA_W-1:0]   w_chk_exp;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      w_drain_nxt = r_drain;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_WRITE;
               w_addr_nxt  = '0;
            end
         end
         ST_WRITE: begin
            if (r_addr == c_last_addr) begin
               w_state_nxt = ST_READ;
               w_addr_nxt  = '0;
            end else begin
               w_addr_nxt = r_addr + 1'b1;
            end
         end
         ST_READ: begin
            if (r_addr == c_last_addr) begin
               w_state_nxt = ST_DRAIN;
               w_addr_nxt  = '0;
               w_drain_nxt = '0;
            end else begin
               w_addr_nxt = r_addr + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (r_drain == c_drain_last) w_state_nxt = ST_DONE;
            else                         w_drain_nxt = r_drain + 1'b1;
         end
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_accept = (r_state == ST_IDLE) && start;

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_addr    <= '0;
         r_drain   <= '0;
         r_en      <= 1'b0;
         r_we      <= 1'b0;
         r_wr_data <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         r_addr    <= w_addr_nxt;
         r_drain   <= w_drain_nxt;
         r_en      <= (w_state_nxt == ST_WRITE) || (w_state_nxt == ST_READ);
         r_we      <= (w_state_nxt == ST_WRITE);
         r_wr_data <= (w_state_nxt == ST_WRITE) ? pattern(w_addr_nxt) : '0;
         r_busy    <= (w_state_nxt == ST_WRITE) || (w_state_nxt == ST_READ) ||
                      (w_state_nxt == ST_DRAIN);
         r_done    <= (w_state_nxt == ST_DONE);
         if (w_accept) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
         end else if (w_mismatch) begin
            r_err     <= 1'b1;
            r_err_cnt <= r_err_cnt + 1'b1;
         end
      end
   end

   rd_chk_pipe #(
      .STAGES (RD_LAT),
      .DATA_W (DATA_W)
   ) u_rd_chk_pipe (
      .clk     (sys_clk),
      .rst     (sys_rst),
      .i_valid (r_state == ST_READ),
      .i_exp   (pattern(r_addr)),
      .o_valid (w_chk_valid),
      .o_exp   (w_chk_exp)
   );

   assign w_mismatch = w_chk_valid && (ram_rd_data != w_chk_exp);

   assign ram_en      = r_en;
   assign ram_we      = r_we;
   assign ram_addr    = r_addr;
   assign ram_wr_data = r_wr_data;
   assign busy        = r_busy;
   assign done        = r_done;
   assign err         = r_err;
   assign err_cnt     = r_err_cnt;

endmodule

`default_nettype wire
